// File: rtl/phys_reg_pkg.sv
// rtl/phys_reg_pkg.sv - shared types, defaults and helpers for the physical register file
package phys_reg_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_PREGS  = 64;
    localparam int DEF_NUM_RD     = 4;
    localparam int DEF_NUM_WR     = 2;
    localparam int PW             = $clog2(DEF_NUM_PREGS);

    // Upper bound on write ports that the match helper can arbitrate
    localparam int MAX_WR = 8;

    typedef logic [PW-1:0] preg_t;

    localparam preg_t PREG_ZERO = '0;

    // Index of the highest set bit in a write-port match vector, -1 when none match
    function automatic int onehot_hi_match(input logic [MAX_WR-1:0] match);
        int idx;
        idx = -1;
        for (int j = 0; j < MAX_WR; j++) begin
            if (match[j]) begin
                idx = j;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/phys_reg_file_mp_if.sv
// rtl/phys_reg_file_mp_if.sv - read/alloc/write/flush bus of the physical register file
interface phys_reg_file_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PREGS  = 64,
    parameter int NUM_RD     = 4,
    parameter int NUM_WR     = 2
);
    localparam int AW = (NUM_PREGS > 1) ? $clog2(NUM_PREGS) : 1;

    logic [NUM_RD-1:0]            rd_en;
    logic [NUM_RD*AW-1:0]         rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]            rd_ready;
    logic                         alloc_en;
    logic [AW-1:0]                alloc_addr;
    logic [NUM_WR-1:0]            wr_en;
    logic [NUM_WR*AW-1:0]         wr_addr;
    logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
    logic                         flush;
    logic                         wr_conflict;

    // Rename/issue and writeback side
    modport master (
        output rd_en, rd_addr, alloc_en, alloc_addr, wr_en, wr_addr, wr_data, flush,
        input  rd_data, rd_ready, wr_conflict
    );

    // Register file side
    modport slave (
        input  rd_en, rd_addr, alloc_en, alloc_addr, wr_en, wr_addr, wr_data, flush,
        output rd_data, rd_ready, wr_conflict
    );

endinterface

// File: rtl/phys_ready_table.sv
// rtl/phys_ready_table.sv - per-register ready scoreboard with alloc, write-set and flush
module phys_ready_table #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_RD    = 4,
    parameter int AW        = 6
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_alloc_en,
    input  logic [AW-1:0]          i_alloc_addr,
    input  logic [NUM_PREGS-1:0]   i_set,
    input  logic                   i_flush,
    input  logic [NUM_RD*AW-1:0]   i_lk_addr,
    output logic [NUM_RD-1:0]      o_lk_ready
);
    localparam logic [AW:0] NP = NUM_PREGS[AW:0];

    logic [NUM_PREGS-1:0] r_ready;
    logic [NUM_PREGS-1:0] w_alloc_mask;
    logic [NUM_PREGS-1:0] w_next;

    // Decode the allocated register; bit 0 never clears so p0 stays ready
    always_comb begin
        w_alloc_mask = '0;
        for (int i = 1; i < NUM_PREGS; i++) begin
            w_alloc_mask[i] = i_alloc_en && (i_alloc_addr == AW'(i));
        end
    end

    // Flush sets everything; otherwise alloc clears after writes have set
    always_comb begin
        w_next = '1;
        if (!i_flush) begin
            w_next = (r_ready | i_set) & ~w_alloc_mask;
        end
    end

    // Scoreboard state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ready <= '1;
        end else begin
            r_ready <= w_next;
        end
    end

    // Combinational ready lookups; out-of-range addresses report ready
    always_comb begin
        o_lk_ready = '1;
        for (int p = 0; p < NUM_RD; p++) begin
            if ({1'b0, i_lk_addr[p*AW +: AW]} < NP) begin
                o_lk_ready[p] = r_ready[i_lk_addr[p*AW +: AW]];
            end
        end
    end

endmodule

// File: rtl/phys_reg_file_mp.sv
// rtl/phys_reg_file_mp.sv - multi-port physical register file with scoreboard, bypass and conflict flag
module phys_reg_file_mp
    import phys_reg_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_PREGS  = DEF_NUM_PREGS,
    parameter int NUM_RD     = DEF_NUM_RD,
    parameter int NUM_WR     = DEF_NUM_WR,
    parameter int BYPASS     = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    phys_reg_file_mp_if.slave    bus
);
    localparam int          AW = (NUM_PREGS > 1) ? $clog2(NUM_PREGS) : 1;
    localparam logic [AW:0] NP = NUM_PREGS[AW:0];

    logic [DATA_WIDTH-1:0]        r_regs [NUM_PREGS];
    logic                         r_conflict;
    logic [NUM_WR-1:0]            w_wr_ok;
    logic [NUM_PREGS-1:0]         w_set;
    logic                         w_conflict;
    logic [NUM_RD-1:0]            w_tbl_ready;
    logic [NUM_RD*DATA_WIDTH-1:0] w_rd_data;
    logic [NUM_RD-1:0]            w_rd_ready;
    logic [MAX_WR-1:0]            w_match [NUM_RD];
    int                           w_hit   [NUM_RD];

    function automatic logic addr_valid(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < NP);
    endfunction

    // Qualify write ports and collect the registers whose ready bit they set
    always_comb begin
        w_wr_ok = '0;
        w_set   = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            w_wr_ok[j] = bus.wr_en[j] && addr_valid(bus.wr_addr[j*AW +: AW]);
            if (w_wr_ok[j]) begin
                w_set[bus.wr_addr[j*AW +: AW]] = 1'b1;
            end
        end
    end

    // Any pair of live write ports aimed at the same register is a conflict
    always_comb begin
        w_conflict = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
            for (int k = j + 1; k < NUM_WR; k++) begin
                if (w_wr_ok[j] && w_wr_ok[k] &&
                    (bus.wr_addr[j*AW +: AW] == bus.wr_addr[k*AW +: AW])) begin
                    w_conflict = 1'b1;
                end
            end
        end
    end

    // Data array; later write ports overwrite earlier ones on a collision
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (w_wr_ok[j]) begin
                    r_regs[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Sticky conflict flag, cleared only by reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_conflict <= 1'b0;
        end else if (w_conflict) begin
            r_conflict <= 1'b1;
        end
    end

    phys_ready_table #(
        .NUM_PREGS (NUM_PREGS),
        .NUM_RD    (NUM_RD),
        .AW        (AW)
    ) u_ready (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_alloc_en   (bus.alloc_en),
        .i_alloc_addr (bus.alloc_addr),
        .i_set        (w_set),
        .i_flush      (bus.flush),
        .i_lk_addr    (bus.rd_addr),
        .o_lk_ready   (w_tbl_ready)
    );

    // Read ports: array lookup, optionally overridden by same-cycle write data
    always_comb begin
        w_rd_data  = '0;
        w_rd_ready = '1;
        for (int p = 0; p < NUM_RD; p++) begin
            w_match[p] = '0;
            w_hit[p]   = -1;
            if (!i_rst && bus.rd_en[p] && addr_valid(bus.rd_addr[p*AW +: AW])) begin
                w_rd_data[p*DATA_WIDTH +: DATA_WIDTH] = r_regs[bus.rd_addr[p*AW +: AW]];
                w_rd_ready[p] = w_tbl_ready[p];
                if (BYPASS != 0) begin
                    for (int j = 0; j < NUM_WR; j++) begin
                        w_match[p][j] = bus.wr_en[j] &&
                                        (bus.wr_addr[j*AW +: AW] == bus.rd_addr[p*AW +: AW]);
                    end
                    w_hit[p] = onehot_hi_match(w_match[p]);
                    if (w_hit[p] >= 0) begin
                        w_rd_data[p*DATA_WIDTH +: DATA_WIDTH] =
                            bus.wr_data[w_hit[p]*DATA_WIDTH +: DATA_WIDTH];
                        w_rd_ready[p] = 1'b1;
                    end
                end
            end
        end
    end

    assign bus.rd_data     = w_rd_data;
    assign bus.rd_ready    = w_rd_ready;
    assign bus.wr_conflict = r_conflict;

endmodule
